// File: rtl/game_select.sv
// game_select: debounced select button -> ROM slot index plus reload handshake.
// Ports: clock, reset_n (sync, active low), btn_raw (pad, 0 = pressed),
//        load_done (loader status) -> reload (1-cycle pulse), index[3:0], busy.
module game_select #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 12500000,
    parameter int NUM_GAMES         = 8,
    parameter int ACK_TIMEOUT       = 1000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic       load_done,
    output logic       reload,
    output logic [3:0] index,
    output logic       busy
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW  = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int AW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [AW-1:0]  ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]     IDX_LAST  = 4'(NUM_GAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_LOAD
    } state_t;

    logic           sync1;
    logic           sync2;
    logic           pressed_sync;
    logic           btn_db;
    logic           btn_db_q;
    logic [DBW-1:0] db_cnt;
    logic           db_rise;
    logic           db_fall;

    state_t         state;
    state_t         state_n;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_n;
    logic [AW-1:0]  ack_cnt;
    logic [AW-1:0]  ack_n;
    logic           ack_seen;
    logic           ack_seen_n;
    logic [3:0]     index_n;
    logic [3:0]     next_index;
    logic           reload_n;

    // Pad is pulled up, so the synchroniser idles at 1 (released).
    assign pressed_sync = ~sync2;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            btn_db_q <= btn_db;
            if (pressed_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= pressed_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Edge-based detection means a button still held when IDLE is
    // re-entered produces no rise, so it must be released first.
    assign db_rise = btn_db & ~btn_db_q;
    assign db_fall = ~btn_db & btn_db_q;

    assign next_index = (index == IDX_LAST) ? 4'd0 : index + 4'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ack_cnt  <= '0;
            ack_seen <= 1'b0;
            index    <= 4'd0;
            reload   <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            ack_cnt  <= ack_n;
            ack_seen <= ack_seen_n;
            index    <= index_n;
            reload   <= reload_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_n     = hold_cnt;
        ack_n      = ack_cnt;
        ack_seen_n = ack_seen;
        index_n    = index;
        reload_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (db_rise) begin
                    state_n = PRESSED;
                    hold_n  = '0;
                end
            end
            PRESSED: begin
                if (db_fall) begin
                    reload_n   = 1'b1;
                    state_n    = WAIT_LOAD;
                    ack_n      = '0;
                    ack_seen_n = 1'b0;
                    // Release on the very cycle the long threshold is
                    // reached still counts as a long press.
                    if (hold_cnt != HOLD_LAST) begin
                        index_n = next_index;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n = LONG_HELD;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (db_fall) begin
                    reload_n   = 1'b1;
                    state_n    = WAIT_LOAD;
                    ack_n      = '0;
                    ack_seen_n = 1'b0;
                end
            end
            WAIT_LOAD: begin
                if (!ack_seen) begin
                    if (!load_done) begin
                        ack_seen_n = 1'b1;
                    end else if (ack_cnt == ACK_LAST) begin
                        state_n = IDLE;
                    end else begin
                        ack_n = ack_cnt + 1'b1;
                    end
                end else if (load_done) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == WAIT_LOAD);

endmodule
